// File: rtl/mem_stage_ctrl.sv
// Memory-access stage behind the EX ALU: passes ALU results through to WB and
// runs LDR/STR over a req/ack handshake, stalling EX while a transfer is open.
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_flush,
    output logic              in_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic              out_we,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              err
);

    // state | meaning
    // IDLE  | accepting EX results; non-memory ops go straight to WB
    // WAIT  | memory transaction outstanding, EX stalled
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0111;
    localparam logic [3:0] OP_STR = 4'b1000;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t            state, state_nxt;
    logic              req_nxt, we_nxt, vld_nxt, owe_nxt, err_nxt;
    logic [DATA_W-1:0] addr_nxt, wdata_nxt, data_nxt;
    logic [RD_W-1:0]   rd_nxt, rd_lat, rd_lat_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              flush_pend, flush_nxt;
    logic              is_mem, wb_en;

    assign in_ready = (state == IDLE);
    assign is_mem   = (in_op == OP_LDR) || (in_op == OP_STR);
    // Arithmetic/logic/SET codes write back; CMP, branch/stall and undefined do not
    assign wb_en    = (in_op <= 4'd6) && (in_op != OP_CMP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            out_valid  <= 1'b0;
            out_we     <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            err        <= 1'b0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            rd_lat     <= '0;
        end else begin
            state      <= state_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            out_valid  <= vld_nxt;
            out_we     <= owe_nxt;
            out_data   <= data_nxt;
            out_rd     <= rd_nxt;
            err        <= err_nxt;
            cnt        <= cnt_nxt;
            flush_pend <= flush_nxt;
            rd_lat     <= rd_lat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = mem_req;
        we_nxt     = mem_we;
        addr_nxt   = mem_addr;
        wdata_nxt  = mem_wdata;
        vld_nxt    = 1'b0;
        owe_nxt    = 1'b0;
        data_nxt   = out_data;
        rd_nxt     = out_rd;
        err_nxt    = err;
        cnt_nxt    = cnt;
        flush_nxt  = flush_pend;
        rd_lat_nxt = rd_lat;
        case (state)
            IDLE: begin
                if (in_valid && !in_flush) begin
                    if (is_mem) begin
                        req_nxt    = 1'b1;
                        we_nxt     = (in_op == OP_STR);
                        addr_nxt   = in_alu_out;
                        wdata_nxt  = (in_op == OP_STR) ? in_store_data : '0;
                        rd_lat_nxt = in_rd;
                        cnt_nxt    = '0;
                        flush_nxt  = 1'b0;
                        state_nxt  = WAIT;
                    end else begin
                        vld_nxt  = 1'b1;
                        owe_nxt  = wb_en;
                        data_nxt = in_alu_out;
                        rd_nxt   = in_rd;
                    end
                end
            end
            WAIT: begin
                // Ack is tested first so an ack on the last allowed cycle still completes
                if (mem_ack) begin
                    req_nxt   = 1'b0;
                    vld_nxt   = 1'b1;
                    owe_nxt   = !mem_we && !flush_pend && !in_flush;
                    data_nxt  = mem_we ? mem_addr : mem_rdata;
                    rd_nxt    = rd_lat;
                    cnt_nxt   = '0;
                    flush_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    vld_nxt   = 1'b1;
                    owe_nxt   = 1'b0;
                    data_nxt  = '0;
                    rd_nxt    = rd_lat;
                    cnt_nxt   = '0;
                    flush_nxt = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    flush_nxt = flush_pend | in_flush;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: expected WB packets are queued at stimulus time
// and compared by a negedge monitor; handshake timing is checked inline.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_flush, mem_ack;
    logic [3:0]  in_op;
    logic [15:0] in_alu_out, in_store_data, mem_rdata;
    logic [3:0]  in_rd;
    logic        in_ready, mem_req, mem_we, out_valid, out_we, err;
    logic [15:0] mem_addr, mem_wdata, out_data;
    logic [3:0]  out_rd;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
        logic [3:0]  rd;
    } pkt_t;

    pkt_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DATA_W(16), .RD_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_op(in_op), .in_alu_out(in_alu_out),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_flush(in_flush),
        .in_ready(in_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_we(out_we), .out_data(out_data), .out_rd(out_rd),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] sd, input logic [3:0] rd);
        in_valid      = v;
        in_op         = op;
        in_alu_out    = a;
        in_store_data = sd;
        in_rd         = rd;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pkt", out_valid, 0);
                end else begin
                    pkt_t e;
                    e = sb_q.pop_front();
                    check("pkt_we", out_we, e.we);
                    check("pkt_data", out_data, e.data);
                    check("pkt_rd", out_rd, e.rd);
                end
            end else begin
                check("we_without_valid", out_we, 0);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        in_flush = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b1;
        step();

        // ADD passes through with latency 1
        drive(1, 4'b0000, 16'h1234, 16'h0, 4'd3);
        sb_q.push_back('{1'b1, 16'h1234, 4'd3});
        step();
        check("add_in_ready", in_ready, 1);

        // CMP then ADD back to back
        drive(1, 4'b0101, 16'h0007, 16'h0, 4'd1);
        sb_q.push_back('{1'b0, 16'h0007, 4'd1});
        step();
        drive(1, 4'b0000, 16'h0008, 16'h0, 4'd2);
        sb_q.push_back('{1'b1, 16'h0008, 4'd2});
        step();
        // undefined op code: no register write
        drive(1, 4'b1110, 16'h0009, 16'h0, 4'd4);
        sb_q.push_back('{1'b0, 16'h0009, 4'd4});
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        step();

        // LDR acked on the third request cycle; an EX result offered during WAIT is ignored
        drive(1, 4'b0111, 16'h0040, 16'h5555, 4'd5);
        sb_q.push_back('{1'b1, 16'hBEEF, 4'd5});
        step();
        drive(1, 4'b0000, 16'hDEAD, 16'h0, 4'd7);
        check("ldr_req_c1", mem_req, 1);
        check("ldr_addr", mem_addr, 16'h0040);
        check("ldr_we", mem_we, 0);
        check("ldr_ready_c1", in_ready, 0);
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        check("ldr_req_c2", mem_req, 1);
        check("ldr_ready_c2", in_ready, 0);
        step();
        check("ldr_req_c3", mem_req, 1);
        check("ldr_addr_c3", mem_addr, 16'h0040);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        mem_rdata = '0;
        check("ldr_req_done", mem_req, 0);
        check("ldr_ready_done", in_ready, 1);
        step();

        // STR flushed mid-wait still completes, packet has no register write
        drive(1, 4'b1000, 16'h0010, 16'h00AA, 4'd2);
        sb_q.push_back('{1'b0, 16'h0010, 4'd2});
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        check("str_we", mem_we, 1);
        check("str_wdata", mem_wdata, 16'h00AA);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        check("str_req_c2", mem_req, 1);
        check("str_wdata_c2", mem_wdata, 16'h00AA);
        step();
        check("str_we_c3", mem_we, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("str_req_done", mem_req, 0);
        step();

        // flush with in_valid in IDLE drops the instruction
        in_flush = 1'b1;
        drive(1, 4'b0111, 16'h0020, 16'h0, 4'd1);
        step();
        in_flush = 1'b0;
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        check("flush_no_req", mem_req, 0);
        check("flush_no_valid", out_valid, 0);
        step();

        // ack on the last allowed cycle wins over timeout
        drive(1, 4'b0111, 16'h0080, 16'h0, 4'd9);
        sb_q.push_back('{1'b1, 16'h1357, 4'd9});
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        repeat (14) step();
        check("edge_req_c15", mem_req, 1);
        mem_ack = 1'b1;
        mem_rdata = 16'h1357;
        step();
        mem_ack = 1'b0;
        check("edge_req_done", mem_req, 0);
        check("edge_no_err", err, 0);
        step();

        // LDR never acked: abort after 15 request cycles
        drive(1, 4'b0111, 16'h0100, 16'h0, 4'd6);
        sb_q.push_back('{1'b0, 16'h0000, 4'd6});
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("tmo_req_cycles", n, 15);
        check("tmo_err", err, 1);
        check("tmo_ready", in_ready, 1);
        step();
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        step();
        check("tmo_err_sticky", err, 1);
        check("tmo_late_ack_req", mem_req, 0);

        // async reset mid-WAIT
        drive(1, 4'b0111, 16'h0200, 16'h0, 4'd8);
        step();
        drive(0, 4'h0, 16'h0, 16'h0, 4'h0);
        step();
        check("rstw_req_before", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("rstw_req", mem_req, 0);
        check("rstw_ready", in_ready, 1);
        check("rstw_err", err, 0);
        #4 rst = 1'b1;
        repeat (3) step();
        check("rstw_no_valid", out_valid, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
